pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst_b  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
REQ-002 SHALL have inputs: id_rs, id_rt  in  5 each  ID source regs; id_uses_rs, id_uses_rt  in  1 each  source actually read; id_halt  in  1  halt (funct 001100) decoded in ID.
REQ-003 SHALL have inputs: ex_rd  in  5  EX dest reg; ex_reg_write  in  1  EX writes reg; ex_mem_read  in  1  EX is a load; mem_rd  in  5  MEM dest reg; mem_reg_write  in  1  MEM writes reg.
REQ-004 SHALL have inputs: ex_branch_taken  in  1  EX resolved taken branch/jump; mem_cache_req  in  1  MEM stage accessing cache; cache_ready  in  1  cache access completes this cycle.
REQ-005 SHALL have outputs: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables; if_id_flush, id_ex_flush  out  1 each  insert bubble.
REQ-006 SHALL have outputs: halted  out  1  pipeline fully drained; state  out  3  current FSM state; stall_cycles  out  16  performance counter.

Function
REQ-007 SHALL implement FSM states RUN, CACHE_WAIT, DRAIN, HALTED; all outputs are decoded from state and current inputs.
REQ-008 Hazard on a source register SHALL require register != 0 and the matching id_uses_* bit.
REQ-009 load_use SHALL be: ex_mem_read & ex_reg_write & ex_rd matches a used source register.
REQ-010 In RUN with no event: all enables=1, flushes=0.
REQ-011 Cache stall (mem_cache_req & !cache_ready) SHALL take highest priority: all enables=0, flushes=0, next state CACHE_WAIT.
REQ-012 CACHE_WAIT SHALL hold all enables=0 until cache_ready=1; in that cycle enables SHALL follow RUN rules and the next state SHALL be RUN, or DRAIN if entered from DRAIN.
REQ-013 Taken branch (priority 2) SHALL force if_id_flush=1 and id_ex_flush=1 with enables=1; a simultaneous load_use or id_halt SHALL be ignored, since the ID instruction is squashed.
REQ-014 load_use (priority 3) SHALL cause a 1-cycle stall: pc_en=0, if_id_en=0, id_ex_flush=1, other enables=1.
REQ-015 id_halt (priority 4) in RUN SHALL set pc_en=0, if_id_en=0, id_ex_en=1, go to DRAIN, and load drain_cnt=3.
REQ-016 DRAIN SHALL keep pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, and decrement drain_cnt each non-stalled cycle; at 0 go to HALTED. A cache stall SHALL pause drain_cnt.
REQ-017 HALTED SHALL be terminal until reset: halted=1, all enables=0, flushes=0; all inputs are ignored.
REQ-018 stall_cycles SHALL increment on every cycle in which pc_en=0 and state != HALTED, and SHALL saturate at 16'hFFFF.
REQ-019 Branch flush SHALL NOT count as a stall.

Reset
REQ-020 While rst_b=0 at a clk edge: state<=RUN, drain_cnt<=0, stall_cycles<=0.
REQ-021 After reset, outputs SHALL be halted=0 and enables/flushes per REQ-010.
REQ-022 Reset mid-DRAIN, mid-CACHE_WAIT or in HALTED SHALL return to RUN in one cycle.

Configuration
REQ-023 Macro PIPELINE_CTRL_FORWARDING_EN defined: only load_use stalls; EX/MEM forwarding is assumed present in the datapath.
REQ-024 Macro undefined: RAW stall (REQ-014 response) SHALL also apply on a source match with ex_rd & ex_reg_write, or with mem_rd & mem_reg_write. Register 0 is still excluded, and the stall persists until no match remains.

Structure
REQ-025 A shared package pipe_pkg SHALL hold the state enum (3-bit encoding RUN=0, CACHE_WAIT=1, DRAIN=2, HALTED=3), the DRAIN_DEPTH=3 constant and the STALL_CNT_W=16 constant.
REQ-026 Hazard comparison SHALL be a sub-module hazard_detect (purely combinational: rs/rt, ex/mem dest, macro-dependent); FSM and counters stay in pipeline_ctrl.

Verification
REQ-027 ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> exactly one cycle pc_en=0, id_ex_flush=1; stall_cycles=1.
REQ-028 Same as REQ-027 with id_rs=0 -> no stall; with ex_branch_taken=1 -> flushes=1, pc_en=1, no stall.
REQ-029 mem_cache_req=1, cache_ready=0 for 4 cycles, then 1 -> enables=0 for 4 cycles; state=CACHE_WAIT; RUN after; stall_cycles=4.
REQ-030 id_halt=1 -> DRAIN for 3 cycles, then halted=1; a 2-cycle cache stall inserted mid-drain extends DRAIN to 5 cycles.
REQ-031 Non-forwarding build: mem_reg_write=1, mem_rd=7, id_rt=7, id_uses_rt=1 -> stall; forwarding build -> no stall.
REQ-032 stall_cycles preloaded near saturation by holding a cache stall 70000 cycles -> reads 16'hFFFF; rst_b=0 one cycle -> 0, state=RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice.
//
// Contents:
//   pipe_state_e : control FSM state (RUN, CACHE_WAIT, DRAIN, HALTED)
//   REG_ADDR_W   : register specifier width
//   DRAIN_DEPTH  : cycles spent draining after a halt
//   DRAIN_CNT_W  : width of the drain counter
//   STALL_CNT_W  : width of the stall-cycle performance counter
package pipe_pkg;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        CACHE_WAIT = 3'd1,
        DRAIN      = 3'd2,
        HALTED     = 3'd3
    } pipe_state_e;

    localparam int REG_ADDR_W  = 5;
    localparam int DRAIN_DEPTH = 3;
    localparam int DRAIN_CNT_W = $clog2(DRAIN_DEPTH + 1);
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: purely combinational source/destination register comparison
// for the instruction sitting in ID.
//
// Ports:
//   id_rs, id_rt             in  source register specifiers in ID
//   id_uses_rs, id_uses_rt   in  source is actually read
//   ex_rd, ex_reg_write      in  EX destination and write enable
//   ex_mem_read              in  EX instruction is a load
//   mem_rd, mem_reg_write    in  MEM destination and write enable
//   load_use                 out load in EX feeds a source read in ID
//   data_stall               out ID must be held for one more cycle
//
// Configuration macro: PIPELINE_CTRL_FORWARDING_EN
//   defined   : EX/MEM results are forwarded, so only load_use stalls
//   undefined : any pending write to a read source register stalls
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    output logic                  load_use,
    output logic                  data_stall
);

    logic rs_live;
    logic rt_live;
    logic ex_match;

    // Register 0 is hardwired to zero, so it never carries a dependency.
    assign rs_live = id_uses_rs && (id_rs != '0);
    assign rt_live = id_uses_rt && (id_rt != '0);

    assign ex_match = ex_reg_write &&
                      ((rs_live && (id_rs == ex_rd)) || (rt_live && (id_rt == ex_rd)));

    assign load_use = ex_mem_read && ex_match;

`ifdef PIPELINE_CTRL_FORWARDING_EN
    assign data_stall = load_use;
`else
    logic mem_match;

    assign mem_match = mem_reg_write &&
                       ((rs_live && (id_rs == mem_rd)) || (rt_live && (id_rt == mem_rd)));

    // Without forwarding, ID waits until every producer has written back.
    assign data_stall = ex_match || mem_match;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for a 5-stage pipeline.
//
// Ports:
//   clk, rst_b                 in  clock, synchronous active-low reset
//   id_rs, id_rt               in  ID source registers
//   id_uses_rs, id_uses_rt     in  source actually read
//   id_halt                    in  halt instruction decoded in ID
//   ex_rd, ex_reg_write        in  EX destination / write enable
//   ex_mem_read                in  EX instruction is a load
//   mem_rd, mem_reg_write      in  MEM destination / write enable
//   ex_branch_taken            in  EX resolved a taken branch/jump
//   mem_cache_req, cache_ready in  MEM cache access / completion
//   pc_en .. mem_wb_en         out stage register enables
//   if_id_flush, id_ex_flush   out bubble insertion
//   halted                     out pipeline fully drained
//   state                      out current FSM state encoding
//   stall_cycles               out saturating count of cycles with pc_en=0
//
// Configuration macro: PIPELINE_CTRL_FORWARDING_EN (see hazard_detect).
module pipeline_ctrl
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   mem_reg_write,
    input  logic                   ex_branch_taken,
    input  logic                   mem_cache_req,
    input  logic                   cache_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   halted,
    output logic [2:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    pipe_state_e            cur_state;
    pipe_state_e            next_state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [DRAIN_CNT_W-1:0] next_drain_cnt;
    logic                   from_drain;
    logic                   next_from_drain;
    logic                   cache_stall;
    logic                   load_use;
    logic                   data_stall;
    logic                   run_rules;
    logic                   drain_rules;

    hazard_detect u_hazard_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .load_use      (load_use),
        .data_stall    (data_stall)
    );

    assign cache_stall = mem_cache_req && !cache_ready;
    assign state       = cur_state;

    // State, drain counter and the "which state to resume after the cache"
    // flag. from_drain lets CACHE_WAIT return to DRAIN with drain_cnt intact.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cur_state  <= RUN;
            drain_cnt  <= '0;
            from_drain <= 1'b0;
        end else begin
            cur_state  <= next_state;
            drain_cnt  <= next_drain_cnt;
            from_drain <= next_from_drain;
        end
    end

    // The state picks which rule set applies this cycle (freeze, RUN rules,
    // DRAIN rules, or halted); the rule sets then decode the outputs. A
    // CACHE_WAIT cycle that sees cache_ready behaves exactly like the state
    // it is resuming, including a DRAIN decrement.
    always_comb begin
        next_state      = cur_state;
        next_drain_cnt  = drain_cnt;
        next_from_drain = from_drain;
        pc_en           = 1'b0;
        if_id_en        = 1'b0;
        id_ex_en        = 1'b0;
        ex_mem_en       = 1'b0;
        mem_wb_en       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        halted          = 1'b0;
        run_rules       = 1'b0;
        drain_rules     = 1'b0;

        case (cur_state)
            RUN: begin
                if (cache_stall) begin
                    next_state      = CACHE_WAIT;
                    next_from_drain = 1'b0;
                end else begin
                    run_rules = 1'b1;
                end
            end
            CACHE_WAIT: begin
                if (cache_ready) begin
                    if (from_drain) begin
                        drain_rules = 1'b1;
                    end else begin
                        run_rules = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cache_stall) begin
                    next_state      = CACHE_WAIT;
                    next_from_drain = 1'b1;
                end else begin
                    drain_rules = 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase

        // A taken branch squashes the ID instruction, so any hazard or halt
        // it carries is irrelevant.
        if (run_rules) begin
            next_state = RUN;
            pc_en      = 1'b1;
            if_id_en   = 1'b1;
            id_ex_en   = 1'b1;
            ex_mem_en  = 1'b1;
            mem_wb_en  = 1'b1;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (data_stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_halt) begin
                pc_en          = 1'b0;
                if_id_en       = 1'b0;
                next_state     = DRAIN;
                next_drain_cnt = DRAIN_CNT_W'(DRAIN_DEPTH);
            end
        end

        // The last decrement (1 -> 0) moves straight to HALTED, so DRAIN
        // lasts DRAIN_DEPTH unstalled cycles.
        if (drain_rules) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (drain_cnt <= DRAIN_CNT_W'(1)) begin
                next_drain_cnt = '0;
                next_state     = HALTED;
            end else begin
                next_drain_cnt = drain_cnt - DRAIN_CNT_W'(1);
                next_state     = DRAIN;
            end
        end
    end

    // Counts fetch-stalled cycles; a branch flush keeps pc_en high and is
    // therefore not counted.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            stall_cycles <= '0;
        end else if (!pc_en && (cur_state != HALTED) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
// Each step idles all inputs at the falling edge, sets the inputs of
// interest, then checks the decoded outputs 1 ns later. Registered values
// (state, stall_cycles) reflect the previous step.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_b;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_halt;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        ex_branch_taken;
    logic        mem_cache_req;
    logic        cache_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Expected number of stalls from the plain RAW vectors (mem match, ex match).
`ifdef PIPELINE_CTRL_FORWARDING_EN
    localparam logic [15:0] RAW_STALLS = 16'd0;
    localparam logic [4:0]  RAW_EN     = 5'b11111;
    localparam logic [1:0]  RAW_FL     = 2'b00;
`else
    localparam logic [15:0] RAW_STALLS = 16'd2;
    localparam logic [4:0]  RAW_EN     = 5'b00111;
    localparam logic [1:0]  RAW_FL     = 2'b01;
`endif

    pipeline_ctrl dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_halt         (id_halt),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .ex_branch_taken (ex_branch_taken),
        .mem_cache_req   (mem_cache_req),
        .cache_ready     (cache_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .halted          (halted),
        .state           (state),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #3000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Wait for the falling edge and return every input to its idle value.
    task automatic applyStimulus();
        @(negedge clk);
        id_rs           = '0;
        id_rt           = '0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_halt         = 1'b0;
        ex_rd           = '0;
        ex_reg_write    = 1'b0;
        ex_mem_read     = 1'b0;
        mem_rd          = '0;
        mem_reg_write   = 1'b0;
        ex_branch_taken = 1'b0;
        mem_cache_req   = 1'b0;
        cache_ready     = 1'b0;
    endtask

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enables as {pc, if_id, id_ex, ex_mem, mem_wb}; flushes as {if_id, id_ex}.
    task automatic checkOutput(input string tag, input logic [4:0] exp_en,
                               input logic [1:0] exp_fl, input logic exp_halted,
                               input logic [2:0] exp_state);
        #1;
        checkVal({tag, ".en"}, {11'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                 {11'd0, exp_en});
        checkVal({tag, ".flush"}, {14'd0, if_id_flush, id_ex_flush}, {14'd0, exp_fl});
        checkVal({tag, ".halted"}, {15'd0, halted}, {15'd0, exp_halted});
        checkVal({tag, ".state"}, {13'd0, state}, {13'd0, exp_state});
    endtask

    initial begin
        rst_b = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_b = 1'b1;
        checkOutput("reset", 5'b11111, 2'b00, 1'b0, RUN);
        checkVal("reset.count", stall_cycles, 16'd0);

        // Load-use on rs: exactly one stalled cycle.
        applyStimulus();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        checkOutput("load_use", 5'b00111, 2'b01, 1'b0, RUN);
        applyStimulus();
        checkOutput("after_lu", 5'b11111, 2'b00, 1'b0, RUN);
        checkVal("lu.count", stall_cycles, 16'd1);

        // Register 0 never creates a dependency.
        applyStimulus();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        checkOutput("lu_r0", 5'b11111, 2'b00, 1'b0, RUN);

        // Taken branch wins over load-use and halt; not counted as stall.
        applyStimulus();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        ex_branch_taken = 1'b1; id_halt = 1'b1;
        checkOutput("branch", 5'b11111, 2'b11, 1'b0, RUN);
        applyStimulus();
        checkVal("branch.count", stall_cycles, 16'd1);

        // Plain RAW against MEM (rt) and EX (rs): build dependent.
        applyStimulus();
        mem_reg_write = 1'b1; mem_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        checkOutput("raw_mem", RAW_EN, RAW_FL, 1'b0, RUN);
        applyStimulus();
        ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        checkOutput("raw_ex", RAW_EN, RAW_FL, 1'b0, RUN);
        // Matching register that is not actually read.
        applyStimulus();
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b0;
        checkOutput("unused_src", 5'b11111, 2'b00, 1'b0, RUN);
        checkVal("raw.count", stall_cycles, 16'd1 + RAW_STALLS);

        // Cache stall: 4 frozen cycles (branch ignored), then resume.
        applyStimulus();
        mem_cache_req = 1'b1; ex_branch_taken = 1'b1;
        checkOutput("cache1", 5'b00000, 2'b00, 1'b0, RUN);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            mem_cache_req = 1'b1;
            checkOutput("cache_wait", 5'b00000, 2'b00, 1'b0, CACHE_WAIT);
        end
        applyStimulus();
        mem_cache_req = 1'b1; cache_ready = 1'b1;
        checkOutput("cache_done", 5'b11111, 2'b00, 1'b0, CACHE_WAIT);
        applyStimulus();
        checkOutput("cache_run", 5'b11111, 2'b00, 1'b0, RUN);
        checkVal("cache.count", stall_cycles, 16'd5 + RAW_STALLS);

        // Halt with a 2-cycle cache stall mid-drain: 5 drain-phase cycles.
        applyStimulus();
        id_halt = 1'b1;
        checkOutput("halt", 5'b00111, 2'b00, 1'b0, RUN);
        applyStimulus();
        checkOutput("drain1", 5'b00111, 2'b11, 1'b0, DRAIN);
        applyStimulus();
        mem_cache_req = 1'b1;
        checkOutput("drain_stall", 5'b00000, 2'b00, 1'b0, DRAIN);
        applyStimulus();
        mem_cache_req = 1'b1;
        checkOutput("drain_cw", 5'b00000, 2'b00, 1'b0, CACHE_WAIT);
        applyStimulus();
        mem_cache_req = 1'b1; cache_ready = 1'b1;
        checkOutput("drain_cw_rdy", 5'b00111, 2'b11, 1'b0, CACHE_WAIT);
        applyStimulus();
        checkOutput("drain_last", 5'b00111, 2'b11, 1'b0, DRAIN);
        applyStimulus();
        checkOutput("halted", 5'b00000, 2'b00, 1'b1, HALTED);
        checkVal("halt.count", stall_cycles, 16'd11 + RAW_STALLS);
        applyStimulus();
        ex_branch_taken = 1'b1; mem_cache_req = 1'b1; id_halt = 1'b1;
        checkOutput("halted_hold", 5'b00000, 2'b00, 1'b1, HALTED);
        checkVal("halted.count", stall_cycles, 16'd11 + RAW_STALLS);

        // Reset out of HALTED.
        applyStimulus();
        rst_b = 1'b0;
        applyStimulus();
        rst_b = 1'b1;
        checkOutput("rst_halted", 5'b11111, 2'b00, 1'b0, RUN);
        checkVal("rst_halted.count", stall_cycles, 16'd0);

        // Unstalled drain lasts exactly three cycles.
        applyStimulus();
        id_halt = 1'b1;
        checkOutput("halt2", 5'b00111, 2'b00, 1'b0, RUN);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("drain_plain", 5'b00111, 2'b11, 1'b0, DRAIN);
        end
        applyStimulus();
        checkOutput("halted2", 5'b00000, 2'b00, 1'b1, HALTED);
        checkVal("halted2.count", stall_cycles, 16'd4);

        // Reset mid-DRAIN.
        applyStimulus();
        rst_b = 1'b0;
        applyStimulus();
        rst_b = 1'b1;
        id_halt = 1'b1;
        checkOutput("halt3", 5'b00111, 2'b00, 1'b0, RUN);
        applyStimulus();
        rst_b = 1'b0;
        applyStimulus();
        rst_b = 1'b1;
        checkOutput("rst_drain", 5'b11111, 2'b00, 1'b0, RUN);

        // Long cache stall saturates the counter; reset mid-CACHE_WAIT.
        for (int i = 0; i < 70000; i++) begin
            applyStimulus();
            mem_cache_req = 1'b1;
        end
        checkOutput("long_cw", 5'b00000, 2'b00, 1'b0, CACHE_WAIT);
        checkVal("saturate", stall_cycles, 16'hFFFF);
        applyStimulus();
        mem_cache_req = 1'b1;
        rst_b = 1'b0;
        applyStimulus();
        rst_b = 1'b1;
        checkOutput("rst_cw", 5'b11111, 2'b00, 1'b0, RUN);
        checkVal("rst_cw.count", stall_cycles, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
